// File: rtl/div_seq_ctrl.sv
// Sequencer for an iterative radix-2 restoring divider (DIV/DIVU/REM/REMU).
// Stalls the pipeline while iterating and returns one result with a single-cycle valid strobe.
module div_seq_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_req_i,
  input  logic [1:0]      div_op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            kill_i,
  output logic            div_stall_o,
  output logic            div_busy_o,
  output logic            div_valid_o,
  output logic [XLEN-1:0] div_result_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   dvs_mag;
  logic              rem_sel;
  logic              neg_quo;
  logic              neg_rem;

  logic              is_signed;
  logic              dvd_neg;
  logic              dvs_neg;
  logic [XLEN-1:0]   dvd_abs;
  logic [XLEN-1:0]   dvs_abs;
  logic              div_zero;
  logic              overflow;
  logic [XLEN-1:0]   spec_result;
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     rem_diff;
  logic [XLEN-1:0]   rem_next;
  logic [XLEN-1:0]   quo_next;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   calc_result;

  // Operand decode for the accept cycle: signedness, magnitudes and the two bypass cases.
  always_comb begin
    is_signed   = ~div_op_i[0];
    dvd_neg     = is_signed & dividend_i[XLEN-1];
    dvs_neg     = is_signed & divisor_i[XLEN-1];
    dvd_abs     = dvd_neg ? (~dividend_i + 1'b1) : dividend_i;
    dvs_abs     = dvs_neg ? (~divisor_i + 1'b1) : divisor_i;
    div_zero    = (divisor_i == '0);
    overflow    = is_signed & (dividend_i == MIN_NEG) & (divisor_i == '1);
    spec_result = '0;
    if (div_op_i[1])
      spec_result = div_zero ? dividend_i : '0;
    else
      spec_result = div_zero ? '1 : MIN_NEG;
  end

  // One restoring step; the extra top bit keeps the remainder MSB and doubles as the borrow.
  always_comb begin
    rem_shift   = {rem_q, quo_q[XLEN-1]};
    rem_diff    = rem_shift - {1'b0, dvs_mag};
    rem_next    = rem_diff[XLEN] ? rem_shift[XLEN-1:0] : rem_diff[XLEN-1:0];
    quo_next    = {quo_q[XLEN-2:0], ~rem_diff[XLEN]};
    quo_fix     = neg_quo ? (~quo_next + 1'b1) : quo_next;
    rem_fix     = neg_rem ? (~rem_next + 1'b1) : rem_next;
    calc_result = rem_sel ? rem_fix : quo_fix;
  end

  // Control FSM; result and valid are loaded on the edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvs_mag      <= '0;
      rem_sel      <= 1'b0;
      neg_quo      <= 1'b0;
      neg_rem      <= 1'b0;
      div_valid_o  <= 1'b0;
      div_result_o <= '0;
    end else begin
      div_valid_o <= 1'b0;
      if (kill_i) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (div_req_i) begin
              rem_sel <= div_op_i[1];
              neg_quo <= dvd_neg ^ dvs_neg;
              neg_rem <= dvd_neg;
              dvs_mag <= dvs_abs;
              rem_q   <= '0;
              quo_q   <= dvd_abs;
              cnt     <= '0;
              if (div_zero || overflow) begin
                state        <= DONE;
                div_result_o <= spec_result;
                div_valid_o  <= 1'b1;
              end else begin
                state <= CALC;
              end
            end
          end
          CALC: begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST_STEP) begin
              state        <= DONE;
              div_result_o <= calc_result;
              div_valid_o  <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign div_busy_o  = (state != IDLE);
  assign div_stall_o = ~rst & div_req_i & ~div_valid_o & ~kill_i;

endmodule
